// File: rtl/signed_minmax_tracker_pkg.sv
// Shared types and constants for the signed min/max tracker.
// State encoding plus default widths and saturation limit.
package signed_minmax_tracker_pkg;

  typedef enum logic [1:0] {
    S_FIRST = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  localparam int unsigned N_DEF       = 32;
  localparam int unsigned CNT_W_DEF   = 16;
  localparam logic [CNT_W_DEF-1:0] CNT_MAX_DEF = '1;

endpackage

// File: rtl/signed_minmax_tracker_slt.sv
// Structural signed less-than: lt_o = (a_i < b_i), two's complement.
// Ripple from LSB; the sign bits override when they differ.
module signed_minmax_tracker_slt #(
  parameter int N = 32
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic         lt_o
);

  logic lt;

  always_comb begin
    lt = 1'b0;
    for (int i = 0; i < N-1; i++) begin
      lt = (~a_i[i] & b_i[i]) |
           (~(a_i[i] ^ b_i[i]) & lt);
    end
    if (a_i[N-1] ^ b_i[N-1]) begin
      lt = a_i[N-1];
    end
    lt_o = lt;
  end

endmodule

// File: rtl/signed_minmax_tracker.sv
// Per-packet running signed min/max/min-index/count tracker.
// One result record per packet on a valid/ready output.
module signed_minmax_tracker
  import signed_minmax_tracker_pkg::*;
#(
  parameter int N       = 32,
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N-1:0]       in_data,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N-1:0]       out_min,
  output logic [N-1:0]       out_max,
  output logic [COUNT_W-1:0] out_min_idx,
  output logic [COUNT_W-1:0] out_count,
  output logic               out_ovf
);

  localparam logic [COUNT_W-1:0] CntMax = '1;
  localparam logic [COUNT_W-1:0] CntOne = COUNT_W'(1);

  state_e             state_q;
  logic               in_ready_q;
  logic               out_valid_q;
  logic [N-1:0]       min_q;
  logic [N-1:0]       max_q;
  logic [COUNT_W-1:0] idx_q;
  logic [COUNT_W-1:0] cnt_q;
  logic [COUNT_W-1:0] cnt_d;
  logic               ovf_q;
  logic               ovf_d;
  logic               min_lt;
  logic               max_lt;

  signed_minmax_tracker_slt #(.N(N)) u_slt_min (
    .a_i  (in_data),
    .b_i  (min_q),
    .lt_o (min_lt)
  );

  signed_minmax_tracker_slt #(.N(N)) u_slt_max (
    .a_i  (max_q),
    .b_i  (in_data),
    .lt_o (max_lt)
  );

  // Counter saturates at all-ones; ovf latches on the first dropped increment.
  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (cnt_q == CntMax) begin
      ovf_d = 1'b1;
    end else begin
      cnt_d = cnt_q + CntOne;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_FIRST;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      min_q       <= '0;
      max_q       <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
    end else begin
      unique case (state_q)
        S_FIRST: begin
          if (in_valid) begin
            min_q <= in_data;
            max_q <= in_data;
            idx_q <= '0;
            cnt_q <= CntOne;
            ovf_q <= 1'b0;
            if (in_last) begin
              state_q     <= S_DONE;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end else begin
              state_q <= S_ACCUM;
            end
          end
        end
        S_ACCUM: begin
          if (in_valid) begin
            if (min_lt) begin
              min_q <= in_data;
              idx_q <= cnt_q;
            end
            if (max_lt) begin
              max_q <= in_data;
            end
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            if (in_last) begin
              state_q     <= S_DONE;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state_q     <= S_FIRST;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= S_FIRST;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_min     = min_q;
  assign out_max     = max_q;
  assign out_min_idx = idx_q;
  assign out_count   = cnt_q;
  assign out_ovf     = ovf_q;

endmodule

// File: tb/tb_signed_minmax_tracker.sv
// Directed bench for signed_minmax_tracker (COUNT_W=16 and COUNT_W=3).
// Both instances share stimulus and stay in lockstep.
module tb_signed_minmax_tracker;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_last;
  logic        out_ready;

  logic        in_ready, out_valid, out_ovf;
  logic [31:0] out_min, out_max;
  logic [15:0] out_min_idx, out_count;

  logic        in_ready3, out_valid3, out_ovf3;
  logic [31:0] out_min3, out_max3;
  logic [2:0]  out_min_idx3, out_count3;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  signed_minmax_tracker #(.N(32), .COUNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_min(out_min), .out_max(out_max),
    .out_min_idx(out_min_idx), .out_count(out_count),
    .out_ovf(out_ovf)
  );

  signed_minmax_tracker #(.N(32), .COUNT_W(3)) dut3 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready3),
    .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid3), .out_ready(out_ready),
    .out_min(out_min3), .out_max(out_max3),
    .out_min_idx(out_min_idx3), .out_count(out_count3),
    .out_ovf(out_ovf3)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] x, input logic last);
    vecs++;
    if (in_ready !== 1'b1) begin
      errs++;
      $display("FAIL send_ready got=%b exp=1", in_ready);
    end
    in_valid = 1'b1;
    in_data  = x;
    in_last  = last;
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    vecs++;
    if ({in_ready, out_valid} !== 2'b10) begin
      errs++;
      $display("FAIL reset_hs got=%b exp=10", {in_ready, out_valid});
    end
    vecs++;
    if ({out_min, out_max, out_min_idx, out_count, out_ovf} !== '0) begin
      errs++;
      $display("FAIL reset_fields min=%h max=%h idx=%0d cnt=%0d ovf=%b exp=all0",
               out_min, out_max, out_min_idx, out_count, out_ovf);
    end
  endtask

  task automatic test_last_ignored();
    in_last = 1'b1;
    step();
    in_last = 1'b0;
    vecs++;
    if ({in_ready, out_valid} !== 2'b10) begin
      errs++;
      $display("FAIL last_no_valid got=%b exp=10", {in_ready, out_valid});
    end
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    send(32'd5, 1'b1);
    vecs++;
    if ({out_valid, in_ready} !== 2'b10) begin
      errs++;
      $display("FAIL single_hs got=%b exp=10", {out_valid, in_ready});
    end
    vecs++;
    if (out_min !== 32'd5 || out_max !== 32'd5 || out_min_idx !== 16'd0 ||
        out_count !== 16'd1 || out_ovf !== 1'b0) begin
      errs++;
      $display("FAIL single_fields min=%h max=%h idx=%0d cnt=%0d ovf=%b exp=5,5,0,1,0",
               out_min, out_max, out_min_idx, out_count, out_ovf);
    end
    step();
    vecs++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errs++;
      $display("FAIL single_release got=%b exp=01", {out_valid, in_ready});
    end
  endtask

  task automatic test_tie();
    send(32'd3, 1'b0);
    send(-32'sd7, 1'b0);
    send(32'd12, 1'b0);
    send(-32'sd7, 1'b0);
    send(32'd0, 1'b1);
    vecs++;
    if (out_valid !== 1'b1 || out_min !== 32'hFFFF_FFF9 ||
        out_max !== 32'd12 || out_min_idx !== 16'd1 || out_count !== 16'd5) begin
      errs++;
      $display("FAIL tie v=%b min=%h max=%h idx=%0d cnt=%0d exp=1,fffffff9,c,1,5",
               out_valid, out_min, out_max, out_min_idx, out_count);
    end
    step();
  endtask

  task automatic test_extremes();
    send(32'h7FFF_FFFF, 1'b0);
    send(32'h8000_0000, 1'b0);
    send(32'h0000_0000, 1'b1);
    vecs++;
    if (out_min !== 32'h8000_0000 || out_max !== 32'h7FFF_FFFF ||
        out_min_idx !== 16'd1 || out_count !== 16'd3) begin
      errs++;
      $display("FAIL extremes min=%h max=%h idx=%0d cnt=%0d exp=80000000,7fffffff,1,3",
               out_min, out_max, out_min_idx, out_count);
    end
    step();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    send(32'd1, 1'b0);
    send(32'd2, 1'b1);
    in_valid = 1'b1;
    in_data  = 32'd99;
    for (int i = 0; i < 4; i++) begin
      vecs++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_min !== 32'd1 ||
          out_max !== 32'd2 || out_count !== 16'd2 || out_min_idx !== 16'd0) begin
        errs++;
        $display("FAIL hold%0d v=%b rdy=%b min=%h max=%h cnt=%0d idx=%0d exp=1,0,1,2,2,0",
                 i, out_valid, in_ready, out_min, out_max, out_count, out_min_idx);
      end
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    vecs++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errs++;
      $display("FAIL bp_release got=%b exp=01", {out_valid, in_ready});
    end
    send(32'd9, 1'b1);
    vecs++;
    if (out_valid !== 1'b1 || out_min !== 32'd9 || out_max !== 32'd9 ||
        out_count !== 16'd1 || out_min_idx !== 16'd0) begin
      errs++;
      $display("FAIL bp_next v=%b min=%h max=%h cnt=%0d idx=%0d exp=1,9,9,1,0",
               out_valid, out_min, out_max, out_count, out_min_idx);
    end
    step();
  endtask

  task automatic test_saturate();
    logic [31:0] pkt [9];
    pkt = '{32'd10, 32'd20, 32'd30, 32'd5, 32'hFFFF_FFFF,
            32'd40, 32'd3, 32'd2, 32'hFFFF_FFCE};
    for (int i = 0; i < 9; i++) begin
      send(pkt[i], i == 8);
    end
    vecs++;
    if (out_valid3 !== 1'b1 || out_count3 !== 3'd7 || out_ovf3 !== 1'b1 ||
        out_min3 !== 32'hFFFF_FFCE || out_max3 !== 32'd40 || out_min_idx3 !== 3'd7) begin
      errs++;
      $display("FAIL sat3 v=%b cnt=%0d ovf=%b min=%h max=%h idx=%0d exp=1,7,1,ffffffce,28,7",
               out_valid3, out_count3, out_ovf3, out_min3, out_max3, out_min_idx3);
    end
    vecs++;
    if (out_count !== 16'd9 || out_ovf !== 1'b0 || out_min_idx !== 16'd8 ||
        out_min !== 32'hFFFF_FFCE || out_max !== 32'd40) begin
      errs++;
      $display("FAIL sat16 cnt=%0d ovf=%b idx=%0d min=%h max=%h exp=9,0,8,ffffffce,28",
               out_count, out_ovf, out_min_idx, out_min, out_max);
    end
    step();
  endtask

  task automatic test_reset_mid();
    send(32'd4, 1'b0);
    send(-32'sd2, 1'b0);
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'd77;
    in_last  = 1'b1;
    step();
    rst      = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    vecs++;
    if ({in_ready, out_valid} !== 2'b10 ||
        {out_min, out_max, out_min_idx, out_count, out_ovf} !== '0) begin
      errs++;
      $display("FAIL rst_mid rdy=%b v=%b min=%h max=%h idx=%0d cnt=%0d ovf=%b exp=1,0,all0",
               in_ready, out_valid, out_min, out_max, out_min_idx, out_count, out_ovf);
    end
    send(32'd6, 1'b1);
    vecs++;
    if (out_valid !== 1'b1 || out_min !== 32'd6 || out_max !== 32'd6 ||
        out_count !== 16'd1 || out_min_idx !== 16'd0) begin
      errs++;
      $display("FAIL rst_next v=%b min=%h max=%h cnt=%0d idx=%0d exp=1,6,6,1,0",
               out_valid, out_min, out_max, out_count, out_min_idx);
    end
    step();
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_last_ignored();
    test_single();
    test_tie();
    test_extremes();
    test_backpressure();
    test_saturate();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
